// File: rtl/uart_rx_pkg.sv
// Shared UART RX constants, sampler state encoding and small helpers used by the
// sampler, deserializer, parity and stop checkers.
package uart_rx_pkg;

  localparam int unsigned PRESC_W = 6;
  localparam int unsigned BIT_W   = 4;

  localparam logic [PRESC_W-1:0] PRESC_8  = PRESC_W'(8);
  localparam logic [PRESC_W-1:0] PRESC_16 = PRESC_W'(16);
  localparam logic [PRESC_W-1:0] PRESC_32 = PRESC_W'(32);

  localparam logic [BIT_W-1:0] FRAME_LAST_PAR   = BIT_W'(10);
  localparam logic [BIT_W-1:0] FRAME_LAST_NOPAR = BIT_W'(9);
  localparam logic [BIT_W-1:0] BIT_START        = BIT_W'(0);
  localparam logic [BIT_W-1:0] BIT_D0           = BIT_W'(1);
  localparam logic [BIT_W-1:0] BIT_D7           = BIT_W'(8);

  typedef enum logic [1:0] {
    SAMP_WAIT,
    SAMP_HAVE0,
    SAMP_HAVE1,
    SAMP_HAVE2
  } samp_state_e;

  // Unsupported oversampling ratios fall back to the slowest-safe ratio of 8.
  function automatic logic [PRESC_W-1:0] presc_legalize(input logic [PRESC_W-1:0] p);
    case (p)
      PRESC_8, PRESC_16, PRESC_32: return p;
      default:                     return PRESC_8;
    endcase
  endfunction

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversample tick and bit-in-frame counters with a prescale latch that only
// follows the prescale input when the counters are started.
module uart_rx_edge_bit_cnt
  import uart_rx_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [PRESC_W-1:0] prescale_i,
  input  logic               par_en_i,
  input  logic               cnt_en_i,
  output logic [PRESC_W-1:0] presc_o,
  output logic [PRESC_W-1:0] edge_cnt_o,
  output logic [BIT_W-1:0]   bit_cnt_o,
  output logic               frame_end_o
);

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] edge_q, edge_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic               cnt_en_q;
  logic               at_wrap;
  logic [BIT_W-1:0]   last_bit;

  assign last_bit = par_en_i ? FRAME_LAST_PAR : FRAME_LAST_NOPAR;
  assign at_wrap  = (edge_q == (presc_q - PRESC_W'(1)));

  always_comb begin
    presc_d = presc_q;
    edge_d  = '0;
    bit_d   = '0;
    // Latch only on the rising edge of cnt_en so mid-frame changes are ignored.
    if (cnt_en_i && !cnt_en_q) begin
      presc_d = presc_legalize(prescale_i);
    end
    if (cnt_en_i) begin
      if (at_wrap) begin
        edge_d = '0;
        bit_d  = (bit_q == last_bit) ? '0 : bit_q + BIT_W'(1);
      end else begin
        edge_d = edge_q + PRESC_W'(1);
        bit_d  = bit_q;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      presc_q  <= PRESC_8;
      edge_q   <= '0;
      bit_q    <= '0;
      cnt_en_q <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      edge_q   <= edge_d;
      bit_q    <= bit_d;
      cnt_en_q <= cnt_en_i;
    end
  end

  assign presc_o     = presc_q;
  assign edge_cnt_o  = edge_q;
  assign bit_cnt_o   = bit_q;
  assign frame_end_o = cnt_en_i && at_wrap && (bit_q == last_bit);

endmodule

// File: rtl/uart_rx_sampler.sv
// UART RX front end: edge/bit counting plus a 3-sample majority vote around the
// middle of each bit, with a one-cycle strobe when the voted value updates.
module uart_rx_sampler
  import uart_rx_pkg::*;
(
  input  logic               CLK,
  input  logic               RST,
  input  logic               RX_IN,
  input  logic [PRESC_W-1:0] prescale,
  input  logic               par_en,
  input  logic               cnt_en,
  input  logic               samp_en,
  output logic [PRESC_W-1:0] edge_cnt,
  output logic [BIT_W-1:0]   bit_cnt,
  output logic               sampled_data,
  output logic               samp_strobe,
  output logic               frame_end
);

  logic [PRESC_W-1:0] presc_q;
  logic [PRESC_W-1:0] mid;
  logic               cap0, cap1, cap2;
  logic [2:0]         samp_q, samp_d;
  samp_state_e        state_q, state_d;
  logic               sampled_q, sampled_d;
  logic               strobe_q, strobe_d;

  uart_rx_edge_bit_cnt u_cnt (
    .clk_i       (CLK),
    .rst_i       (RST),
    .prescale_i  (prescale),
    .par_en_i    (par_en),
    .cnt_en_i    (cnt_en),
    .presc_o     (presc_q),
    .edge_cnt_o  (edge_cnt),
    .bit_cnt_o   (bit_cnt),
    .frame_end_o (frame_end)
  );

  assign mid  = presc_q >> 1;
  assign cap0 = samp_en && (edge_cnt == (mid - PRESC_W'(1)));
  assign cap1 = samp_en && (edge_cnt == mid);
  assign cap2 = samp_en && (edge_cnt == (mid + PRESC_W'(1)));

  // The state tracks an unbroken run of captures; any gap drops back to WAIT
  // so a vote is only taken on three samples from the same bit.
  always_comb begin
    state_d   = SAMP_WAIT;
    samp_d    = samp_q;
    sampled_d = sampled_q;
    strobe_d  = 1'b0;
    if (cap0) samp_d[0] = RX_IN;
    if (cap1) samp_d[1] = RX_IN;
    if (cap2) samp_d[2] = RX_IN;
    case (state_q)
      SAMP_WAIT: begin
        if (cap0) state_d = SAMP_HAVE0;
      end
      SAMP_HAVE0: begin
        if (cap1)      state_d = SAMP_HAVE1;
        else if (cap0) state_d = SAMP_HAVE0;
      end
      SAMP_HAVE1: begin
        if (cap2)      state_d = SAMP_HAVE2;
        else if (cap0) state_d = SAMP_HAVE0;
      end
      SAMP_HAVE2: begin
        if (samp_en) begin
          sampled_d = maj3(samp_q);
          strobe_d  = 1'b1;
        end
      end
      default: state_d = SAMP_WAIT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= SAMP_WAIT;
      samp_q    <= 3'b111;
      sampled_q <= 1'b1;
      strobe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      samp_q    <= samp_d;
      sampled_q <= sampled_d;
      strobe_q  <= strobe_d;
    end
  end

  assign sampled_data = sampled_q;
  assign samp_strobe  = strobe_q;

endmodule
